// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory stage: access sizes, FSM states,
// result-source selection and the byte-lane derivation helper.
package dm_pkg;

    // Access size as carried on mem_size_ex.
    typedef enum logic {
        SZ_BYTE = 1'b0,
        SZ_WORD = 1'b1
    } size_e;

    // IDLE accepts requests; SPLIT finishes the second half of a misaligned word.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SPLIT = 1'b1
    } state_e;

    // Where ans_dm takes its value from in the cycle after an edge.
    typedef enum logic [1:0] {
        KIND_PASS  = 2'd0,   // captured value (ALU result, zero on error, held value)
        KIND_BYTE  = 2'd1,   // one lane of the RAM read word, extended
        KIND_WORD  = 2'd2,   // the aligned RAM read word as-is
        KIND_SPLIT = 2'd3    // upper lanes of the held word joined with lower lanes of the read word
    } result_kind_e;

    // Number of byte lanes in a datapath word.
    function automatic int lanes_of(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dm_byte_ram.sv
// Single-port synchronous RAM with one write enable per byte lane and a
// registered read port. Contents are never reset.
module dm_byte_ram
    import dm_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic                         clk,
    input  logic [IDX_W-1:0]             addr,
    input  logic [lanes_of(DATA_W)-1:0]  we,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DATA_W-1:0]            rdata
);

    localparam int LANES = lanes_of(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Write the enabled lanes and register the old word at the same address.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (we[l]) begin
                mem[addr][l*8 +: 8] <= wdata[l*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_stage.sv
// MEM pipeline stage: byte/word loads and stores on a byte-addressed RAM,
// misaligned words split over two cycles with a stall, out-of-range accesses
// flagged and suppressed, and the memory result muxed against the ALU result.
module data_mem_stage
    import dm_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] DM_data,
    input  logic              mem_en_ex,
    input  logic              mem_rw_ex,
    input  logic              mem_size_ex,
    input  logic              mem_sext_ex,
    input  logic              mem_mux_sel_dm,
    output logic [DATA_W-1:0] ans_dm,
    output logic              stall,
    output logic              addr_err
);

    localparam int LANES = lanes_of(DATA_W);
    localparam int OFF_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // Request decode
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] widx;
    logic [OFF_W-1:0]  off;
    logic [63:0]       widx_w;
    logic              is_word;
    logic              misaligned;
    logic              range_err;

    // FSM
    state_e state_q, state_d;

    // RAM port
    logic [IDX_W-1:0]  ram_addr;
    logic [LANES-1:0]  ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Request latched for the second half of a misaligned word
    logic [IDX_W-1:0]  req_widx_q;
    logic [OFF_W-1:0]  req_off_q;
    logic              req_rw_q;
    logic              req_sel_q;
    logic [DATA_W-1:0] req_data_q;
    logic [DATA_W-1:0] req_ans_q;

    // Result registers feeding the output mux
    result_kind_e      kind_q;
    logic [DATA_W-1:0] pass_q;
    logic [DATA_W-1:0] hold_q;
    logic [OFF_W-1:0]  rd_off_q;
    logic              rd_sext_q;
    logic              err_q;

    assign addr       = ans_ex[ADDR_W-1:0];
    assign widx       = addr / ADDR_W'(LANES);
    assign off        = OFF_W'(addr % ADDR_W'(LANES));
    assign widx_w     = 64'(widx);
    assign is_word    = (size_e'(mem_size_ex) == SZ_WORD);
    assign misaligned = is_word && (off != '0);
    assign range_err  = (widx_w >= 64'(DEPTH_WORDS)) ||
                        (misaligned && ((widx_w + 64'd1) >= 64'(DEPTH_WORDS)));

    assign stall    = (state_q == S_SPLIT);
    assign addr_err = err_q;

    dm_byte_ram #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // State register; reset abandons any pending second half.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus RAM address/lane enables; store data is rotated so each byte lands in its lane.
    always_comb begin
        state_d   = state_q;
        ram_addr  = IDX_W'(widx);
        ram_we    = '0;
        ram_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (mem_en_ex && !range_err) begin
                    if (misaligned) begin
                        state_d = S_SPLIT;
                    end
                    if (mem_rw_ex) begin
                        if (!is_word) begin
                            ram_we[off] = 1'b1;
                            ram_wdata[int'(off)*8 +: 8] = DM_data[7:0];
                        end else begin
                            for (int k = 0; k < LANES; k++) begin
                                if (k >= int'(off)) begin
                                    ram_we[k] = 1'b1;
                                    ram_wdata[k*8 +: 8] = DM_data[(k - int'(off))*8 +: 8];
                                end
                            end
                        end
                    end
                end
            end
            S_SPLIT: begin
                state_d  = S_IDLE;
                ram_addr = req_widx_q + IDX_W'(1);
                if (req_rw_q) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (k < int'(req_off_q)) begin
                            ram_we[k] = 1'b1;
                            ram_wdata[k*8 +: 8] = req_data_q[(k + LANES - int'(req_off_q))*8 +: 8];
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (reset) begin
            ram_we = '0;
        end
    end

    // Capture what ans_dm should show after this edge and latch split requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q <= KIND_PASS;
            pass_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_en_ex && range_err) begin
                        err_q  <= 1'b1;
                        kind_q <= KIND_PASS;
                        pass_q <= (!mem_rw_ex && mem_mux_sel_dm) ? '0 : ans_ex;
                    end else if (mem_en_ex && misaligned) begin
                        req_widx_q <= IDX_W'(widx);
                        req_off_q  <= off;
                        req_rw_q   <= mem_rw_ex;
                        req_sel_q  <= mem_mux_sel_dm;
                        req_data_q <= DM_data;
                        req_ans_q  <= ans_ex;
                        kind_q     <= KIND_PASS;
                        pass_q     <= ans_dm;
                    end else if (mem_en_ex && !mem_rw_ex && mem_mux_sel_dm) begin
                        kind_q    <= is_word ? KIND_WORD : KIND_BYTE;
                        rd_off_q  <= off;
                        rd_sext_q <= mem_sext_ex;
                    end else begin
                        kind_q <= KIND_PASS;
                        pass_q <= ans_ex;
                    end
                end
                S_SPLIT: begin
                    if (!req_rw_q && req_sel_q) begin
                        kind_q   <= KIND_SPLIT;
                        hold_q   <= ram_rdata;
                        rd_off_q <= req_off_q;
                    end else begin
                        kind_q <= KIND_PASS;
                        pass_q <= req_ans_q;
                    end
                end
                default: kind_q <= KIND_PASS;
            endcase
        end
    end

    // Output mux: every source is a register, so ans_dm changes only after a clock edge.
    always_comb begin
        logic [7:0] sel_byte;
        sel_byte = ram_rdata[int'(rd_off_q)*8 +: 8];
        ans_dm   = pass_q;
        case (kind_q)
            KIND_PASS: ans_dm = pass_q;
            KIND_BYTE: ans_dm = {{(DATA_W-8){rd_sext_q & sel_byte[7]}}, sel_byte};
            KIND_WORD: ans_dm = ram_rdata;
            KIND_SPLIT: begin
                for (int j = 0; j < LANES; j++) begin
                    if (j < LANES - int'(rd_off_q)) begin
                        ans_dm[j*8 +: 8] = hold_q[(j + int'(rd_off_q))*8 +: 8];
                    end else begin
                        ans_dm[j*8 +: 8] = ram_rdata[(j + int'(rd_off_q) - LANES)*8 +: 8];
                    end
                end
            end
            default: ans_dm = pass_q;
        endcase
    end

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage at default parameters, using a
// byte-array memory model and directed plus randomized request sequences.
module tb_data_mem_stage;

    localparam int NBYTES = 512;

    logic        clk;
    logic        reset;
    logic [15:0] ans_ex;
    logic [15:0] DM_data;
    logic        mem_en_ex;
    logic        mem_rw_ex;
    logic        mem_size_ex;
    logic        mem_sext_ex;
    logic        mem_mux_sel_dm;
    logic [15:0] ans_dm;
    logic        stall;
    logic        addr_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] model_mem [NBYTES];

    data_mem_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ans_ex         (ans_ex),
        .DM_data        (DM_data),
        .mem_en_ex      (mem_en_ex),
        .mem_rw_ex      (mem_rw_ex),
        .mem_size_ex    (mem_size_ex),
        .mem_sext_ex    (mem_sext_ex),
        .mem_mux_sel_dm (mem_mux_sel_dm),
        .ans_dm         (ans_dm),
        .stall          (stall),
        .addr_err       (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit in case the DUT never releases the bench.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: byte-addressed memory, little-endian words, whole-access range check.
    function automatic logic [15:0] model_exec(input logic en, input logic rw, input logic size,
                                               input logic sext, input logic sel,
                                               input logic [15:0] ans, input logic [15:0] data,
                                               output logic exp_err, output int exp_stalls);
        int a;
        int nbytes;
        logic [15:0] r;
        a          = int'(ans);
        nbytes     = size ? 2 : 1;
        exp_err    = 1'b0;
        exp_stalls = 0;
        if (!en) return ans;
        if (a + nbytes > NBYTES) begin
            exp_err = 1'b1;
            return (!rw && sel) ? 16'h0000 : ans;
        end
        if (size && (a % 2 != 0)) exp_stalls = 1;
        if (rw) begin
            model_mem[a] = data[7:0];
            if (size) model_mem[a+1] = data[15:8];
            return ans;
        end
        if (!sel) return ans;
        if (size) begin
            r = {model_mem[a+1], model_mem[a]};
        end else begin
            r = {8'h00, model_mem[a]};
            if (sext && model_mem[a][7]) r[15:8] = 8'hFF;
        end
        return r;
    endfunction

    // Drive one request, then wait out any stall (bounded); outputs are valid on return.
    task automatic issue(input logic en, input logic rw, input logic size, input logic sext,
                         input logic sel, input logic [15:0] ans, input logic [15:0] data,
                         output int stalls);
        @(negedge clk);
        mem_en_ex      = en;
        mem_rw_ex      = rw;
        mem_size_ex    = size;
        mem_sext_ex    = sext;
        mem_mux_sel_dm = sel;
        ans_ex         = ans;
        DM_data        = data;
        @(posedge clk);
        #1;
        mem_en_ex = 1'b0;
        stalls    = 0;
        while (stall === 1'b1 && stalls < 4) begin
            stalls++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_en_ex = 1'b0; mem_rw_ex = 1'b0; mem_size_ex = 1'b0;
        mem_sext_ex = 1'b0; mem_mux_sel_dm = 1'b0;
        ans_ex = 16'h5A5A; DM_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ans_dm !== 16'h0000) begin errors++; $display("[TB] FAIL reset_ans_dm: got %h expected 0000", ans_dm); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
        checks++;
        if (addr_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_addr_err: got %b expected 0", addr_err); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_clear_memory();
        int s;
        for (int w = 0; w < NBYTES/2; w++) begin
            issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'(2*w), 16'h0000, s);
        end
        for (int b = 0; b < NBYTES; b++) model_mem[b] = 8'h00;
    endtask

    task automatic test_pass_through();
        int s;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'hFFFF, s);
        checks++;
        if (ans_dm !== 16'h1234) begin errors++; $display("[TB] FAIL pass_ans_dm: got %h expected 1234", ans_dm); end
        checks++;
        if (stall !== 1'b0 || s != 0) begin errors++; $display("[TB] FAIL pass_stall: got %b/%0d expected 0/0", stall, s); end
        checks++;
        if (addr_err !== 1'b0) begin errors++; $display("[TB] FAIL pass_addr_err: got %b expected 0", addr_err); end
        // A load with the mux on the ALU side still returns ans_ex.
        issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, s);
        checks++;
        if (ans_dm !== 16'h0010) begin errors++; $display("[TB] FAIL pass_load_alu_side: got %h expected 0010", ans_dm); end
    endtask

    task automatic test_byte();
        int s;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0080, s);
        model_mem[5] = 8'h80;
        issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 16'h0000, s);
        checks++;
        if (ans_dm !== 16'hFF80) begin errors++; $display("[TB] FAIL byte_load_sext: got %h expected FF80", ans_dm); end
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005, 16'h0000, s);
        checks++;
        if (ans_dm !== 16'h0080) begin errors++; $display("[TB] FAIL byte_load_zext: got %h expected 0080", ans_dm); end
    endtask

    task automatic test_misaligned_store();
        int s;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000, s);
        issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, s);
        model_mem[2] = 8'h00; model_mem[3] = 8'h00; model_mem[4] = 8'h00; model_mem[5] = 8'h00;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0003, 16'hBEEF, s);
        model_mem[3] = 8'hEF; model_mem[4] = 8'hBE;
        checks++;
        if (s != 1) begin errors++; $display("[TB] FAIL mis_store_stall_cycles: got %0d expected 1", s); end
        issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 16'h0000, s);
        checks++;
        if (ans_dm !== 16'hEF00) begin errors++; $display("[TB] FAIL mis_store_low_word: got %h expected EF00", ans_dm); end
        issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000, s);
        checks++;
        if (ans_dm !== 16'h00BE) begin errors++; $display("[TB] FAIL mis_store_high_word: got %h expected 00BE", ans_dm); end
    endtask

    task automatic test_misaligned_load();
        int s;
        issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h0000, s);
        checks++;
        if (s != 1) begin errors++; $display("[TB] FAIL mis_load_stall_cycles: got %0d expected 1", s); end
        checks++;
        if (ans_dm !== 16'hBEEF) begin errors++; $display("[TB] FAIL mis_load_data: got %h expected BEEF", ans_dm); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("[TB] FAIL mis_load_stall_release: got %b expected 0", stall); end
    endtask

    task automatic test_out_of_range();
        int s;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h1357, s);
        checks++;
        if (addr_err !== 1'b1) begin errors++; $display("[TB] FAIL oor_store_err: got %b expected 1", addr_err); end
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, s);
        checks++;
        if (addr_err !== 1'b0) begin errors++; $display("[TB] FAIL oor_err_pulse_width: got %b expected 0", addr_err); end
        issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h01FF, 16'hA5C3, s);
        checks++;
        if (addr_err !== 1'b1) begin errors++; $display("[TB] FAIL oor_mis_store_err: got %b expected 1", addr_err); end
        checks++;
        if (s != 0) begin errors++; $display("[TB] FAIL oor_mis_store_stall: got %0d expected 0", s); end
        issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h01FE, 16'h0000, s);
        checks++;
        if (ans_dm !== {model_mem[511], model_mem[510]}) begin
            errors++; $display("[TB] FAIL oor_word255_unchanged: got %h expected %h", ans_dm, {model_mem[511], model_mem[510]});
        end
        issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8001, 16'h0000, s);
        checks++;
        if (ans_dm !== 16'h0000 || addr_err !== 1'b1) begin
            errors++; $display("[TB] FAIL oor_load_zero: got %h/%b expected 0000/1", ans_dm, addr_err);
        end
    endtask

    task automatic test_reset_in_split();
        int s;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000, s);
        issue(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, s);
        model_mem[2] = 8'h00; model_mem[3] = 8'h00; model_mem[4] = 8'h00; model_mem[5] = 8'h00;
        @(negedge clk);
        mem_en_ex = 1'b1; mem_rw_ex = 1'b1; mem_size_ex = 1'b1;
        mem_sext_ex = 1'b0; mem_mux_sel_dm = 1'b0;
        ans_ex = 16'h0003; DM_data = 16'hBEEF;
        @(posedge clk);
        #1;
        mem_en_ex = 1'b0;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("[TB] FAIL rst_split_stall_entered: got %b expected 1", stall); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || ans_dm !== 16'h0000) begin
            errors++; $display("[TB] FAIL rst_split_abort: got stall=%b ans_dm=%h expected 0/0000", stall, ans_dm);
        end
        @(negedge clk);
        reset = 1'b0;
        model_mem[3] = 8'hEF;
        issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0002, 16'h0000, s);
        checks++;
        if (ans_dm !== 16'hEF00) begin errors++; $display("[TB] FAIL rst_split_first_half: got %h expected EF00", ans_dm); end
        issue(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000, s);
        checks++;
        if (ans_dm !== 16'h0000) begin errors++; $display("[TB] FAIL rst_split_second_half: got %h expected 0000", ans_dm); end
    endtask

    task automatic test_random();
        int s, exp_s, r;
        logic en, rw, size, sext, sel, exp_err;
        logic [15:0] a, d, exp;
        for (int i = 0; i < 300; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            rw   = $urandom_range(0, 1) == 1;
            size = $urandom_range(0, 1) == 1;
            sext = $urandom_range(0, 1) == 1;
            sel  = ($urandom_range(0, 4) != 0);
            d    = 16'($urandom);
            r    = $urandom_range(0, 9);
            if (r == 0)      a = 16'h01FF;
            else if (r == 1) a = 16'h01FE;
            else if (r == 2) a = 16'($urandom_range(16'h0200, 16'hFFFF));
            else             a = 16'($urandom_range(0, 16'h0040));
            exp = model_exec(en, rw, size, sext, sel, a, d, exp_err, exp_s);
            issue(en, rw, size, sext, sel, a, d, s);
            checks++;
            if (ans_dm !== exp || addr_err !== exp_err || s != exp_s) begin
                errors++;
                $display("[TB] FAIL random_op%0d: got ans_dm=%h err=%b stalls=%0d expected %h/%b/%0d (en=%b rw=%b sz=%b sx=%b sel=%b a=%h d=%h)",
                         i, ans_dm, addr_err, s, exp, exp_err, exp_s, en, rw, size, sext, sel, a, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear_memory();
        test_pass_through();
        test_byte();
        test_misaligned_store();
        test_misaligned_load();
        test_out_of_range();
        test_reset_in_split();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_stage.md
Name: data_mem_stage

Overview:
Parametrised data-memory pipeline stage for the MIPS core. It sits between EX and WB, performs byte- and word-sized loads and stores on a byte-addressed synchronous RAM, and muxes the memory result against the ALU result into ans_dm. Compared with the fixed 16-bit block, it adds configurable width and depth, byte lanes with sign extension, two-cycle misaligned word access with a stall handshake, and address-range checking.

Parameters:
DATA_W, 16, datapath width in bits; must be a multiple of 8 and at least 16.
ADDR_W, 16, number of byte-address bits taken from ans_ex[ADDR_W-1:0].
DEPTH_WORDS, 256, number of DATA_W-wide words in the RAM.
LANES, DATA_W/8, derived constant, not overridable; number of byte lanes.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
ans_ex  in  DATA_W  ALU result; byte address for memory ops; pass-through value otherwise.
DM_data  in  DATA_W  store data; byte stores use DM_data[7:0].
mem_en_ex  in  1  1 = memory op this cycle.
mem_rw_ex  in  1  1 = store, 0 = load.
mem_size_ex  in  1  0 = byte, 1 = word.
mem_sext_ex  in  1  byte load: 1 = sign-extend, 0 = zero-extend.
mem_mux_sel_dm  in  1  1 = ans_dm takes memory data on loads, 0 = ans_dm takes ans_ex.
ans_dm  out  DATA_W  registered stage result.
stall  out  1  high while a misaligned access is in its second cycle; upstream must hold.
addr_err  out  1  one-cycle pulse, aligned with ans_dm, on an out-of-range access.

Behaviour:
- Address split: off = addr mod LANES; widx = addr / LANES. Little-endian: the byte at addr maps to lane off; a word's LSB sits at the lowest address.
- Reset (synchronous):
  - ans_dm=0, stall=0, addr_err=0, FSM goes to IDLE.
  - RAM contents are not cleared.
- FSM states: IDLE, SPLIT.
- Inputs are sampled only in IDLE; they are ignored while in SPLIT.
- IDLE with mem_en_ex=0, or with mem_en_ex=1 and mem_mux_sel_dm=0 on a load: ans_dm <= ans_ex. Latency is 1 cycle.
- Aligned access (byte, or word with off=0):
  - Completes in 1 cycle.
  - Store writes only the enabled lanes at the clock edge.
  - Load: ans_dm <= read data at the same edge, so it is visible in the next cycle.
  - Store: ans_dm <= ans_ex.
- Byte load: lane off, zero- or sign-extended to DATA_W according to mem_sext_ex.
- Misaligned word (off!=0):
  - Cycle 1 (IDLE):
    - Latch the request.
    - Access lanes off..LANES-1 of widx.
    - Next state is SPLIT; stall=1 (registered) during SPLIT.
  - Cycle 2 (SPLIT):
    - Access lanes 0..off-1 of widx+1.
    - ans_dm is updated at the end of SPLIT.
    - Return to IDLE; stall=0.
  - Total latency is 2 cycles.
- Range check: an access is checked atomically. If widx >= DEPTH_WORDS, or it is a misaligned word and widx+1 >= DEPTH_WORDS:
  - No lane is written.
  - A load returns 0.
  - addr_err=1 for one cycle with the result.
  - No SPLIT is entered.
- Read-after-write: a store at edge N is visible to a load sampled at edge N+1. No bypass is needed.
- Reset asserted during SPLIT: abort. The first-half write persists, the second half is dropped, stall=0.
- Upper address bits of ans_ex above ADDR_W are ignored.

Decomposition:
- Package dm_pkg:
  - size encodings SZ_BYTE, SZ_WORD;
  - FSM state constants S_IDLE, S_SPLIT;
  - LANES derivation helper.
- Sub-module dm_byte_ram:
  - single-port synchronous RAM with DEPTH_WORDS x DATA_W, per-lane write enables, registered read data;
  - instantiated once inside data_mem_stage.
- FSM, lane alignment/rotation, sign extension and the output mux live in the top module.

Test Plan (defaults DATA_W=16, DEPTH_WORDS=256):
1. Pass-through: mem_en_ex=0, ans_ex=0x1234 -> ans_dm=0x1234 one cycle later; stall=0, addr_err=0.
2. Byte store and loads: store byte DM_data=0x0080 at addr 0x0005; load byte 0x0005 with sext=1 -> 0xFF80; with sext=0 -> 0x0080.
3. Misaligned store: store word 0x0000 to 0x0002 and to 0x0004; store word 0xBEEF to 0x0003 -> stall=1 for exactly one cycle; load 0x0002 -> 0xEF00; load 0x0004 -> 0x00BE.
4. Misaligned load: load word 0x0003 -> stall=1 for one cycle, then ans_dm=0xBEEF; total latency 2 cycles.
5. Out of range:
   - Store to 0x0200 -> addr_err pulse, no write.
   - Misaligned store to 0x01FF -> addr_err pulse, no stall, and word 255 is unchanged on readback.
6. Reset in SPLIT: misaligned store 0xBEEF to 0x0003, assert reset during the stall cycle -> stall=0, ans_dm=0; readback 0x0002=0xEF00 and 0x0004 unchanged at 0x0000.
